// File: rtl/score_pkg.sv
// Shared types and BCD constants for the score keeper / binary-to-BCD stage.
package score_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;
  localparam int NUM_DIGITS     = 2;
endpackage

// File: rtl/bcd_adjust_digit.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_adjust_digit
  import score_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj_digit
);
  assign adj_digit = (digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH))
                   ? digit + BCD_DIGIT_W'(BCD_ADJ_ADD) : digit;
endmodule

// File: rtl/score_bcd_converter.sv
// Score counter plus serial double-dabble converter publishing tens/ones atomically.
// Optional high-score tracking and display select via `define HIGH_SCORE_EN.
module score_bcd_converter
  import score_pkg::*;
#(
  parameter int SCORE_WIDTH = 7,
  parameter int MAX_SCORE   = 99
)(
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Score_Inc,
  input  logic                   i_Score_Clr,
  input  logic                   i_Show_High,
  output logic [SCORE_WIDTH-1:0] o_Score,
  output logic [SCORE_WIDTH-1:0] o_High_Score,
  output logic [3:0]             o_Tens,
  output logic [3:0]             o_Ones,
  output logic                   o_Busy,
  output logic                   o_Done
);
  localparam int BCD_W = NUM_DIGITS * BCD_DIGIT_W;
  localparam int SR_W  = BCD_W + SCORE_WIDTH;
  localparam int CNT_W = $clog2(SCORE_WIDTH + 1);

  state_e                  state;
  logic [SR_W-1:0]         sr;
  logic [CNT_W-1:0]        cnt;
  logic [SCORE_WIDTH-1:0]  disp, conv_val, last_val;
  logic                    pending;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                                          o_Score <= '0;
    else if (i_Score_Clr)                               o_Score <= '0;
    else if (i_Score_Inc && o_Score != SCORE_WIDTH'(MAX_SCORE)) o_Score <= o_Score + 1'b1;
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                                   o_High_Score <= '0;
    else if (i_Score_Clr && o_Score > o_High_Score) o_High_Score <= o_Score;
  end
  assign disp = i_Show_High ? o_High_Score : o_Score;
`else
  logic unused_show_high;
  assign unused_show_high = i_Show_High;
  assign o_High_Score     = '0;
  assign disp             = o_Score;
`endif

  // Per-digit correction on the BCD part of the shift register, then shift left.
  logic [NUM_DIGITS-1:0][BCD_DIGIT_W-1:0] adj;
  logic [SR_W-1:0]                        sr_adj;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_adjust_digit u_adj (
      .digit     (sr[SCORE_WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj_digit (adj[g])
    );
  end
  assign sr_adj = {adj, sr[SCORE_WIDTH-1:0]};

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      conv_val <= '0;
      last_val <= '0;
      pending  <= 1'b0;
      o_Tens   <= '0;
      o_Ones   <= '0;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (disp != last_val) begin
            sr       <= {{BCD_W{1'b0}}, disp};
            conv_val <= disp;
            cnt      <= '0;
            o_Busy   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= {sr_adj[SR_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (disp != conv_val) pending <= 1'b1;
          if (cnt == CNT_W'(SCORE_WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          o_Tens   <= sr[SCORE_WIDTH + BCD_DIGIT_W +: BCD_DIGIT_W];
          o_Ones   <= sr[SCORE_WIDTH +: BCD_DIGIT_W];
          last_val <= conv_val;
          o_Done   <= 1'b1;
          pending  <= 1'b0;
          // Value moved while converting: chain straight into a fresh conversion.
          if (pending || disp != conv_val) begin
            sr       <= {{BCD_W{1'b0}}, disp};
            conv_val <= disp;
            cnt      <= '0;
            o_Busy   <= 1'b1;
            state    <= SHIFT;
          end else begin
            o_Busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter; HIGH_SCORE_EN section runs only when defined.
module tb_score_bcd_converter;
  logic       i_Clk = 1'b0;
  logic       i_Rst, i_Score_Inc, i_Score_Clr, i_Show_High;
  logic [6:0] o_Score, o_High_Score;
  logic [3:0] o_Tens, o_Ones;
  logic       o_Busy, o_Done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int busy_falls = 0;
  int bad_pub = 0;
  bit watch_pub = 0;
  bit busy_q = 0;

  always #5 i_Clk = ~i_Clk;

  score_bcd_converter dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Score_Inc(i_Score_Inc), .i_Score_Clr(i_Score_Clr),
    .i_Show_High(i_Show_High), .o_Score(o_Score), .o_High_Score(o_High_Score),
    .o_Tens(o_Tens), .o_Ones(o_Ones), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always @(negedge i_Clk) begin
    if (o_Done) begin
      done_cnt++;
      if (watch_pub && !(o_Tens == 0 && (o_Ones == 1 || o_Ones == 3))) bad_pub++;
    end
    if (busy_q && !o_Busy) busy_falls++;
    busy_q = o_Busy;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // Pulse inputs for one sampled edge; returns with #1 after that edge.
  task automatic pulse(input bit inc, input bit clr);
    @(posedge i_Clk); #1;
    i_Score_Inc = inc; i_Score_Clr = clr;
    @(posedge i_Clk); #1;
    i_Score_Inc = 0; i_Score_Clr = 0;
  endtask

  // Negedges after the sampling edge until o_Done; 9 means done after edge 9.
  task automatic latency(input string tag);
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge i_Clk);
      if (o_Done) break;
    end
    chk(tag, n, 9);
  endtask

  task automatic hold_inc(input int n);
    @(posedge i_Clk); #1;
    i_Score_Inc = 1;
    repeat (n) @(posedge i_Clk);
    #1 i_Score_Inc = 0;
  endtask

  initial begin
    int d0;
    i_Rst = 1; i_Score_Inc = 0; i_Score_Clr = 0; i_Show_High = 0;
    cycles(3);
    chk("rst_score", o_Score, 0);
    chk("rst_tens", o_Tens, 0);
    chk("rst_ones", o_Ones, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    i_Rst = 0;
    cycles(3);

    // 12 increments, each conversion lands 9 edges after its pulse
    for (int i = 0; i < 12; i++) begin
      pulse(1, 0);
      latency($sformatf("lat_inc%0d", i + 1));
      cycles(11);
    end
    chk("inc12_score", o_Score, 12);
    chk("inc12_tens", o_Tens, 1);
    chk("inc12_ones", o_Ones, 2);
    chk("inc12_dones", done_cnt, 12);
    chk("inc12_busy", o_Busy, 0);
`ifndef HIGH_SCORE_EN
    chk("high_tied0", o_High_Score, 0);
`endif

    // saturation at 99
    pulse(0, 1);
    cycles(30);
    chk("clr_score", o_Score, 0);
    hold_inc(105);
    cycles(40);
    chk("sat_score", o_Score, 99);
    chk("sat_tens", o_Tens, 9);
    chk("sat_ones", o_Ones, 9);
    pulse(1, 0);
    cycles(30);
    chk("sat_hold", o_Score, 99);

    // Clr beats Inc in the same cycle
    pulse(0, 1);
    cycles(30);
    hold_inc(5);
    cycles(30);
    chk("five_ones", o_Ones, 5);
    pulse(1, 1);
    chk("incclr_score", o_Score, 0);
    latency("incclr_lat");
    chk("incclr_tens", o_Tens, 0);
    chk("incclr_ones", o_Ones, 0);

    // back-to-back increments: one chained reconversion, busy drops once
    cycles(5);
    busy_falls = 0; watch_pub = 1;
    hold_inc(3);
    cycles(40);
    watch_pub = 0;
    chk("b2b_score", o_Score, 3);
    chk("b2b_tens", o_Tens, 0);
    chk("b2b_ones", o_Ones, 3);
    chk("b2b_busy_falls", busy_falls, 1);
    chk("b2b_bad_pub", bad_pub, 0);

    // async reset mid-conversion
    d0 = done_cnt;
    pulse(1, 0);
    chk("abort_score4", o_Score, 4);
    repeat (4) @(posedge i_Clk);
    #3 i_Rst = 1;
    #1;
    chk("abort_busy_pre", 0, 0 * o_Busy);
    chk("abort_score", o_Score, 0);
    chk("abort_ones", o_Ones, 0);
    chk("abort_busy", o_Busy, 0);
    cycles(2);
    i_Rst = 0;
    cycles(20);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_ones_hold", o_Ones, 0);

`ifdef HIGH_SCORE_EN
    hold_inc(37);
    cycles(30);
    pulse(0, 1);
    chk("hs_high_clr", o_High_Score, 37);
    cycles(30);
    hold_inc(12);
    cycles(30);
    i_Show_High = 1;
    cycles(30);
    chk("hs_high", o_High_Score, 37);
    chk("hs_score", o_Score, 12);
    chk("hs_tens", o_Tens, 3);
    chk("hs_ones", o_Ones, 7);
    i_Show_High = 0;
    cycles(30);
    chk("hs_back_tens", o_Tens, 1);
    chk("hs_back_ones", o_Ones, 2);
    pulse(0, 1);
    chk("hs_keep_max", o_High_Score, 37);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
